uart_prog_loader: RTL and testbench

- Packet-based program-memory loader for the PicoSoC board top.
- Consumes a received UART byte stream while programming mode is enabled and parses framed packets.
- Emits one single-cycle 32-bit write per received word to the SoC program memory, verifies an 8-bit checksum, and returns a one-byte response.
- Sits between the UART RX/TX byte interfaces and the picosoc_noflash progmem write port, alongside the debounced-button and BUFG clock logic.

---
 rtl/uart_prog_loader.sv | 203 ++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Packet-based progmem loader: parses SOP/CMD/LEN/data/CS/EOP frames from the UART RX
// byte stream, issues one 32-bit progmem write per word and answers with one response byte.
module uart_prog_loader #(
  parameter logic [7:0]  SOP      = 8'h23,
  parameter logic [7:0]  EOP      = 8'h0D,
  parameter logic [7:0]  CMD_WR   = 8'h07,
  parameter logic [7:0]  ACK_OK   = 8'h55,
  parameter logic [15:0] DISP_RST = 16'd1234
) (
  input  logic        clk_bufg,
  input  logic        resetn,
  input  logic        prog_en,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        pm_wen,
  output logic [31:0] pm_addr,
  output logic [31:0] pm_wdata,
  output logic [7:0]  cmd,
  output logic [15:0] disp,
  output logic [5:0]  status
);

  localparam int unsigned ST_W  = 4;
  localparam int unsigned CNT_W = 16;

  localparam logic [ST_W-1:0] ST_WAIT_SOP = 4'd0;
  localparam logic [ST_W-1:0] ST_CMD      = 4'd1;
  localparam logic [ST_W-1:0] ST_LEN_LB   = 4'd2;
  localparam logic [ST_W-1:0] ST_LEN_HB   = 4'd3;
  localparam logic [ST_W-1:0] ST_D0       = 4'd4;
  localparam logic [ST_W-1:0] ST_D1       = 4'd5;
  localparam logic [ST_W-1:0] ST_D2       = 4'd6;
  localparam logic [ST_W-1:0] ST_D3       = 4'd7;
  localparam logic [ST_W-1:0] ST_CS       = 4'd8;
  localparam logic [ST_W-1:0] ST_EOP      = 4'd9;
  localparam logic [ST_W-1:0] ST_FIN      = 4'd10;
  localparam logic [ST_W-1:0] ST_ERR      = 4'd11;

  logic [ST_W-1:0]  state, state_nxt;
  logic [7:0]       checksum, checksum_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [CNT_W-1:0] length, length_nxt;
  logic [23:0]      word, word_nxt;
  logic [7:0]       tx_data_nxt, cmd_nxt;
  logic             tx_start_nxt, pm_wen_nxt;
  logic [31:0]      pm_addr_nxt, pm_wdata_nxt;
  logic [15:0]      disp_nxt;
  logic [5:0]       status_nxt;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] length_full;

  assign count_inc   = count + CNT_W'(1);
  assign length_full = {rx_data, length[7:0]};

  // State and datapath registers
  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      state    <= ST_WAIT_SOP;
      checksum <= '0;
      count    <= '0;
      length   <= '0;
      word     <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      pm_wen   <= 1'b0;
      pm_addr  <= 32'hFFFF_FFFF;
      pm_wdata <= '0;
      cmd      <= '0;
      disp     <= DISP_RST;
      status   <= '0;
    end else begin
      state    <= state_nxt;
      checksum <= checksum_nxt;
      count    <= count_nxt;
      length   <= length_nxt;
      word     <= word_nxt;
      tx_data  <= tx_data_nxt;
      tx_start <= tx_start_nxt;
      pm_wen   <= pm_wen_nxt;
      pm_addr  <= pm_addr_nxt;
      pm_wdata <= pm_wdata_nxt;
      cmd      <= cmd_nxt;
      disp     <= disp_nxt;
      status   <= status_nxt;
    end
  end

  // Next-state and next-output logic; strobes default low every cycle
  always_comb begin
    state_nxt    = state;
    checksum_nxt = checksum;
    count_nxt    = count;
    length_nxt   = length;
    word_nxt     = word;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;
    pm_wen_nxt   = 1'b0;
    pm_addr_nxt  = pm_addr;
    pm_wdata_nxt = pm_wdata;
    cmd_nxt      = cmd;
    disp_nxt     = disp;
    status_nxt   = status;

    if (!prog_en) begin
      state_nxt = ST_WAIT_SOP;
    end else begin
      case (state)
        ST_WAIT_SOP: begin
          status_nxt = '0;
          count_nxt  = '0;
          cmd_nxt    = '0;
          if (rx_valid && rx_data == SOP) begin
            checksum_nxt = '0;
            length_nxt   = '0;
            status_nxt   = 6'b00_0001;
            state_nxt    = ST_CMD;
          end
        end
        ST_CMD: begin
          if (rx_valid) begin
            cmd_nxt   = rx_data;
            state_nxt = ST_LEN_LB;
          end
        end
        ST_LEN_LB: begin
          if (rx_valid) begin
            length_nxt[7:0] = rx_data;
            state_nxt       = ST_LEN_HB;
          end
        end
        ST_LEN_HB: begin
          if (rx_valid) begin
            length_nxt = length_full;
            state_nxt  = (length_full == '0) ? ST_CS : ST_D0;
          end
        end
        ST_D0: begin
          if (rx_valid) begin
            word_nxt[7:0] = rx_data;
            checksum_nxt  = checksum + rx_data;
            state_nxt     = ST_D1;
          end
        end
        ST_D1: begin
          if (rx_valid) begin
            word_nxt[15:8] = rx_data;
            checksum_nxt   = checksum + rx_data;
            state_nxt      = ST_D2;
          end
        end
        ST_D2: begin
          if (rx_valid) begin
            word_nxt[23:16] = rx_data;
            checksum_nxt    = checksum + rx_data;
            state_nxt       = ST_D3;
          end
        end
        ST_D3: begin
          // Last byte of a word: commit the write and advance the word address
          if (rx_valid) begin
            checksum_nxt  = checksum + rx_data;
            pm_wdata_nxt  = {rx_data, word};
            pm_addr_nxt   = {16'd0, count};
            pm_wen_nxt    = (cmd == CMD_WR);
            count_nxt     = count_inc;
            disp_nxt      = count_inc;
            status_nxt[1] = 1'b1;
            state_nxt     = (count_inc == length) ? ST_CS : ST_D0;
          end
        end
        ST_CS: begin
          status_nxt[2] = 1'b1;
          if (rx_valid) state_nxt = (rx_data == checksum) ? ST_EOP : ST_ERR;
        end
        ST_EOP: begin
          status_nxt[3] = 1'b1;
          if (rx_valid) state_nxt = (rx_data == EOP) ? ST_FIN : ST_ERR;
        end
        ST_FIN: begin
          status_nxt[5] = 1'b1;
          tx_data_nxt   = ACK_OK;
          if (tx_ready) begin
            tx_start_nxt = 1'b1;
            state_nxt    = ST_WAIT_SOP;
          end
        end
        ST_ERR: begin
          status_nxt[4] = 1'b1;
          tx_data_nxt   = checksum;
          if (tx_ready) begin
            tx_start_nxt = 1'b1;
            state_nxt    = ST_WAIT_SOP;
          end
        end
        default: state_nxt = ST_WAIT_SOP;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader: packets are built from the framing rules and
// expected writes/responses are queued and checked against the DUT every cycle.
module tb_uart_prog_loader;

  logic        clk_bufg = 1'b0;
  logic        resetn;
  logic        prog_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        pm_wen;
  logic [31:0] pm_addr;
  logic [31:0] pm_wdata;
  logic [7:0]  cmd;
  logic [15:0] disp;
  logic [5:0]  status;

  uart_prog_loader dut (
    .clk_bufg(clk_bufg), .resetn(resetn), .prog_en(prog_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .pm_wen(pm_wen),
    .pm_addr(pm_addr), .pm_wdata(pm_wdata), .cmd(cmd),
    .disp(disp), .status(status)
  );

  always #5 clk_bufg = ~clk_bufg;

  int total = 0;
  int bad   = 0;
  bit hold_low = 1'b0;
  logic [15:0] disp_model;

  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [7:0]  exp_tx[$];
  logic [5:0]  exp_st[$];
  logic [15:0] exp_disp[$];
  logic [7:0]  exp_cmd[$];
  logic [7:0]  byte_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  task automatic push_resp(input logic [7:0] t, input logic [5:0] s, input logic [15:0] d,
                           input logic [7:0] c);
    exp_tx.push_back(t);
    exp_st.push_back(s);
    exp_disp.push_back(d);
    exp_cmd.push_back(c);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_bufg);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_bufg);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk_bufg);
  endtask

  task automatic send_bytes();
    foreach (byte_q[i]) send_byte(byte_q[i]);
    byte_q.delete();
  endtask

  task automatic flush_exp();
    exp_wa.delete(); exp_wd.delete(); exp_tx.delete();
    exp_st.delete(); exp_disp.delete(); exp_cmd.delete();
  endtask

  // Wait (bounded) for the queued response, then confirm idle WAIT_SOP behaviour
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 4000) begin
      @(posedge clk_bufg);
      n++;
    end
    repeat (3) @(posedge clk_bufg);
    #1;
    if (exp_tx.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no response expected tx_data %h", name, exp_tx[0]);
    end
    check({name, "_wr_left"}, 32'(exp_wa.size()), 32'd0);
    check({name, "_idle_status"}, 32'(status), 32'd0);
    check({name, "_idle_cmd"}, 32'(cmd), 32'd0);
    flush_exp();
  endtask

  // Reference model: builds a frame and queues what it must produce
  task automatic rand_packet(input logic [7:0] c, input int unsigned len);
    logic [15:0] l;
    logic [7:0]  cs;
    logic [31:0] w;
    bit          cs_bad, eop_bad;
    logic [5:0]  st;
    l  = 16'(len);
    cs = 8'd0;
    byte_q.push_back(8'h23);
    byte_q.push_back(c);
    byte_q.push_back(l[7:0]);
    byte_q.push_back(l[15:8]);
    for (int i = 0; i < int'(len); i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        byte_q.push_back(w[8*b +: 8]);
        cs = 8'(cs + w[8*b +: 8]);
      end
      if (c == 8'h07) push_wr(32'(i), w);
    end
    cs_bad  = ($urandom_range(0, 4) == 0);
    eop_bad = !cs_bad && ($urandom_range(0, 4) == 0);
    byte_q.push_back(cs_bad ? 8'(cs + 8'($urandom_range(1, 255))) : cs);
    byte_q.push_back(eop_bad ? (8'h0D ^ 8'($urandom_range(1, 15))) : 8'h0D);
    if (len > 0) disp_model = l;
    st = 6'h01 | ((len > 0) ? 6'h02 : 6'h00) | 6'h04 | (cs_bad ? 6'h00 : 6'h08)
       | ((cs_bad || eop_bad) ? 6'h10 : 6'h20);
    push_resp((cs_bad || eop_bad) ? cs : 8'h55, st, disp_model, c);
  endtask

  task automatic garbage();
    logic [7:0] g;
    repeat ($urandom_range(0, 3)) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'h23) g = 8'h00;
      byte_q.push_back(g);
    end
  endtask

  // TX handshake partner
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk_bufg);
      tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Per-cycle compare of write and response strobes against the model queues
  initial begin
    forever begin
      @(posedge clk_bufg);
      #1;
      if (pm_wen) begin
        if (exp_wa.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_unexpected: got write addr %h data %h expected none", pm_addr, pm_wdata);
        end else begin
          check("wr_addr", pm_addr, exp_wa.pop_front());
          check("wr_data", pm_wdata, exp_wd.pop_front());
        end
      end
      if (tx_start) begin
        check("tx_start_ready", 32'(tx_ready), 32'd1);
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got tx_start data %h expected none", tx_data);
        end else begin
          check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
          check("tx_status", 32'(status), 32'(exp_st.pop_front()));
          check("tx_disp", 32'(disp), 32'(exp_disp.pop_front()));
          check("tx_cmd", 32'(cmd), 32'(exp_cmd.pop_front()));
        end
      end
    end
  end

  task automatic check_reset_vals(input string name);
    check({name, "_pm_wen"}, 32'(pm_wen), 32'd0);
    check({name, "_pm_addr"}, pm_addr, 32'hFFFF_FFFF);
    check({name, "_pm_wdata"}, pm_wdata, 32'd0);
    check({name, "_disp"}, 32'(disp), 32'd1234);
    check({name, "_status"}, 32'(status), 32'd0);
    check({name, "_cmd"}, 32'(cmd), 32'd0);
    check({name, "_tx_start"}, 32'(tx_start), 32'd0);
    check({name, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    prog_en  = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    disp_model = 16'd1234;
    repeat (3) @(posedge clk_bufg);
    #1;
    check_reset_vals("rst");
    @(negedge clk_bufg);
    resetn = 1'b1;
    repeat (5) @(posedge clk_bufg);
    #1;
    check("idle_disp", 32'(disp), 32'd1234);
    check("idle_addr", pm_addr, 32'hFFFF_FFFF);

    // Hand-computed packets
    byte_q = '{8'h23, 8'h07, 8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h0D};
    push_wr(32'd0, 32'h0000_0093);
    push_resp(8'h55, 6'h2F, 16'd1, 8'h07);
    send_bytes();
    wait_done("one_word");

    byte_q = '{8'h23, 8'h07, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00,
               8'h13, 8'h02, 8'h00, 8'h00, 8'hA8, 8'h0D};
    push_wr(32'd0, 32'h0000_0093);
    push_wr(32'd1, 32'h0000_0213);
    push_resp(8'h55, 6'h2F, 16'd2, 8'h07);
    send_bytes();
    wait_done("two_words");

    byte_q = '{8'h23, 8'h07, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h0D};
    push_wr(32'd0, 32'h0403_0201);
    push_resp(8'h0A, 6'h17, 16'd1, 8'h07);
    send_bytes();
    wait_done("bad_cs");

    byte_q = '{8'h23, 8'h07, 8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h0E};
    push_wr(32'd0, 32'h0000_0093);
    push_resp(8'h93, 6'h1F, 16'd1, 8'h07);
    send_bytes();
    wait_done("bad_eop");

    byte_q = '{8'h23, 8'h07, 8'h00, 8'h00, 8'h00, 8'h0D};
    push_resp(8'h55, 6'h2D, 16'd1, 8'h07);
    send_bytes();
    wait_done("len0");

    byte_q = '{8'h23, 8'h08, 8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h0D};
    push_resp(8'h55, 6'h2F, 16'd1, 8'h08);
    send_bytes();
    wait_done("no_wr_cmd");

    // Response must wait for tx_ready
    hold_low = 1'b1;
    byte_q = '{8'h23, 8'h07, 8'h01, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h0D};
    push_wr(32'd0, 32'h0000_0093);
    push_resp(8'h55, 6'h2F, 16'd1, 8'h07);
    send_bytes();
    repeat (30) @(posedge clk_bufg);
    #1;
    check("resp_waits", 32'(exp_tx.size()), 32'd1);
    hold_low = 1'b0;
    wait_done("hold_ready");
    disp_model = 16'd1;

    // prog_en dropped mid-word: no write, no response, trailing bytes ignored
    byte_q = '{8'h23, 8'h07, 8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes();
    @(negedge clk_bufg);
    prog_en = 1'b0;
    repeat (5) @(negedge clk_bufg);
    prog_en = 1'b1;
    byte_q = '{8'h33, 8'h44, 8'h77, 8'h0D};
    send_bytes();
    wait_done("prog_en_drop");

    // Reset mid-packet
    byte_q = '{8'h23, 8'h07, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_bytes();
    @(negedge clk_bufg);
    resetn = 1'b0;
    @(posedge clk_bufg);
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk_bufg);
    resetn = 1'b1;
    disp_model = 16'd1234;
    byte_q = '{8'h44, 8'h0D};
    send_bytes();
    wait_done("after_rst");

    // Word count crossing the low length byte
    rand_packet(8'h07, 260);
    send_bytes();
    wait_done("len260");

    for (int k = 0; k < 25; k++) begin
      logic [7:0] c;
      case ($urandom_range(0, 2))
        0:       c = 8'h07;
        1:       c = 8'h08;
        default: c = 8'($urandom_range(0, 255));
      endcase
      garbage();
      rand_packet(c, $urandom_range(0, 5));
      send_bytes();
      wait_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
